// File: rtl/decode_pkg.sv
// Shared encodings for the pipelined control decoder: opcodes, functs,
// control-bundle layout, ALU/RegControl encodings and the decode FSM states.
package decode_pkg;

    localparam int unsigned ALUMODE_W = 4;
    localparam int unsigned ALUIN_W   = 4;
    localparam int unsigned REGCTL_W  = 5;
    localparam int unsigned CTRL_W    = 10 + ALUMODE_W + ALUIN_W + REGCTL_W;

    // Bundle bit offsets (LSB first), matching the ctrl_t packing below
    localparam int unsigned OFS_REGCTL  = 0;
    localparam int unsigned OFS_ALUIN   = OFS_REGCTL + REGCTL_W;
    localparam int unsigned OFS_ALUMODE = OFS_ALUIN + ALUIN_W;
    localparam int unsigned OFS_IM      = OFS_ALUMODE + ALUMODE_W;
    localparam int unsigned OFS_SYSCALL = OFS_IM + 1;
    localparam int unsigned OFS_HALF    = OFS_SYSCALL + 1;
    localparam int unsigned OFS_MEMWR   = OFS_HALF + 1;
    localparam int unsigned OFS_BGEZ    = OFS_MEMWR + 1;
    localparam int unsigned OFS_BNE     = OFS_BGEZ + 1;
    localparam int unsigned OFS_BEQ     = OFS_BNE + 1;
    localparam int unsigned OFS_JR      = OFS_BEQ + 1;
    localparam int unsigned OFS_JW      = OFS_JR + 1;
    localparam int unsigned OFS_J       = OFS_JW + 1;

    typedef struct packed {
        logic                 j;
        logic                 jw;
        logic                 jr;
        logic                 beq;
        logic                 bne;
        logic                 bgez;
        logic                 mem_write;
        logic                 half;
        logic                 syscall;
        logic                 im;
        logic [ALUMODE_W-1:0] alu_mode;
        logic [ALUIN_W-1:0]   alu_input;
        logic [REGCTL_W-1:0]  reg_control;
    } ctrl_t;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_SLT     = 6'h2A;

    localparam logic [4:0] RT_BGEZ    = 5'd1;

    localparam logic [ALUMODE_W-1:0] ALU_NOP = 4'd0;
    localparam logic [ALUMODE_W-1:0] ALU_ADD = 4'd1;
    localparam logic [ALUMODE_W-1:0] ALU_SUB = 4'd2;
    localparam logic [ALUMODE_W-1:0] ALU_AND = 4'd3;
    localparam logic [ALUMODE_W-1:0] ALU_OR  = 4'd4;
    localparam logic [ALUMODE_W-1:0] ALU_SLT = 4'd5;
    localparam logic [ALUMODE_W-1:0] ALU_LUI = 4'd6;

    localparam logic [ALUIN_W-1:0] ALUIN_NONE  = 4'd0;
    localparam logic [ALUIN_W-1:0] ALUIN_REG   = 4'd1;
    localparam logic [ALUIN_W-1:0] ALUIN_IMM_S = 4'd2;
    localparam logic [ALUIN_W-1:0] ALUIN_IMM_Z = 4'd3;

    // RegControl: bit0 write enable, [2:1] dest (0 rd, 1 rt, 2 $ra), bit3 from memory, bit4 link PC
    localparam logic [REGCTL_W-1:0] REGCTL_NONE = 5'b00000;
    localparam logic [REGCTL_W-1:0] REGCTL_RD   = 5'b00001;
    localparam logic [REGCTL_W-1:0] REGCTL_RT   = 5'b00011;
    localparam logic [REGCTL_W-1:0] REGCTL_MEM  = 5'b01011;
    localparam logic [REGCTL_W-1:0] REGCTL_RA   = 5'b10101;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    function automatic ctrl_t alu_op(input logic [ALUMODE_W-1:0] mode,
                                     input logic [ALUIN_W-1:0]   src,
                                     input logic [REGCTL_W-1:0]  dst,
                                     input logic                 imm);
        ctrl_t c;
        c             = '0;
        c.alu_mode    = mode;
        c.alu_input   = src;
        c.reg_control = dst;
        c.im          = imm;
        return c;
    endfunction

endpackage

// File: rtl/decode_logic.sv
// Combinational instruction decode: opcode/funct/rt fields to control bundle.
import decode_pkg::*;

module decode_logic (
    input  logic [5:0] op,
    input  logic [4:0] rt,
    input  logic [5:0] funct,
    output ctrl_t      ctrl_c,
    output logic       uses_rt_c
);

    always_comb begin
        ctrl_c    = '0;
        uses_rt_c = 1'b0;
        if (op == OP_SPECIAL) begin
            uses_rt_c = 1'b1;
            case (funct)
                FN_ADD, FN_ADDU: ctrl_c = alu_op(ALU_ADD, ALUIN_REG, REGCTL_RD, 1'b0);
                FN_SUB:          ctrl_c = alu_op(ALU_SUB, ALUIN_REG, REGCTL_RD, 1'b0);
                FN_AND:          ctrl_c = alu_op(ALU_AND, ALUIN_REG, REGCTL_RD, 1'b0);
                FN_OR:           ctrl_c = alu_op(ALU_OR,  ALUIN_REG, REGCTL_RD, 1'b0);
                FN_SLT:          ctrl_c = alu_op(ALU_SLT, ALUIN_REG, REGCTL_RD, 1'b0);
                FN_JR:           ctrl_c.jr = 1'b1;
                FN_SYSCALL:      ctrl_c.syscall = 1'b1;
                default:         ctrl_c = '0;
            endcase
        end else begin
            case (op)
                OP_J:   ctrl_c.j = 1'b1;
                OP_JAL: begin
                    ctrl_c.j           = 1'b1;
                    ctrl_c.jw          = 1'b1;
                    ctrl_c.reg_control = REGCTL_RA;
                end
                OP_BEQ: begin
                    ctrl_c     = alu_op(ALU_SUB, ALUIN_REG, REGCTL_NONE, 1'b0);
                    ctrl_c.beq = 1'b1;
                    uses_rt_c  = 1'b1;
                end
                OP_BNE: begin
                    ctrl_c     = alu_op(ALU_SUB, ALUIN_REG, REGCTL_NONE, 1'b0);
                    ctrl_c.bne = 1'b1;
                    uses_rt_c  = 1'b1;
                end
                OP_REGIMM:         ctrl_c.bgez = (rt == RT_BGEZ);
                OP_ADDI, OP_ADDIU: ctrl_c = alu_op(ALU_ADD, ALUIN_IMM_S, REGCTL_RT, 1'b1);
                OP_ANDI:           ctrl_c = alu_op(ALU_AND, ALUIN_IMM_Z, REGCTL_RT, 1'b1);
                OP_ORI:            ctrl_c = alu_op(ALU_OR,  ALUIN_IMM_Z, REGCTL_RT, 1'b1);
                OP_LUI:            ctrl_c = alu_op(ALU_LUI, ALUIN_IMM_Z, REGCTL_RT, 1'b1);
                OP_LW:             ctrl_c = alu_op(ALU_ADD, ALUIN_IMM_S, REGCTL_MEM, 1'b1);
                OP_SW, OP_SH: begin
                    ctrl_c           = alu_op(ALU_ADD, ALUIN_IMM_S, REGCTL_NONE, 1'b1);
                    ctrl_c.mem_write = 1'b1;
                    ctrl_c.half      = (op == OP_SH);
                    uses_rt_c        = 1'b1;
                end
                default: ctrl_c = '0;
            endcase
        end
    end

endmodule

// File: rtl/pipe_decode_ctrl.sv
// ID stage: decodes one instruction per cycle into the ID/EX register with a
// valid/ready handshake, load-use stall, flush, syscall drain/halt and stall counter.
import decode_pkg::*;

module pipe_decode_ctrl #(
    parameter int unsigned PC_W         = 32,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [4:0]        out_rs,
    output logic [4:0]        out_rt,
    output logic [4:0]        out_rd,
    output logic [31:0]       out_instr,
    output logic [PC_W-1:0]   out_pc,
    input  logic              ex_memread,
    input  logic [4:0]        ex_rd,
    input  logic              flush,
    input  logic              resume,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_count
);

    localparam int unsigned DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    state_t             state;
    logic [DRAIN_W-1:0] drain_cnt;
    ctrl_t              dec_ctrl;
    logic               dec_uses_rt;
    logic               hazard;
    logic               accept;

    decode_logic u_decode (
        .op        (in_instr[31:26]),
        .rt        (in_instr[20:16]),
        .funct     (in_instr[5:0]),
        .ctrl_c    (dec_ctrl),
        .uses_rt_c (dec_uses_rt)
    );

    // Load-use: the EX load writes a register this instruction reads
    assign hazard = ex_memread && (ex_rd != 5'd0) && in_valid &&
                    ((ex_rd == in_instr[25:21]) || (dec_uses_rt && (ex_rd == in_instr[20:16])));
    assign in_ready = (state == RUN) && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    assign out_rs = out_instr[25:21];
    assign out_rt = out_instr[20:16];
    assign out_rd = out_instr[15:11];

    // ID/EX register; a flush discards any same-cycle accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
            out_instr <= '0;
            out_pc    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_ctrl  <= dec_ctrl;
            out_instr <= in_instr;
            out_pc    <= in_pc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Syscall FSM: drain the downstream pipe after the syscall leaves, then halt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            halted    <= 1'b0;
            drain_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (accept && !flush && dec_ctrl.syscall) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_W'(DRAIN_CYCLES);
                    end
                end
                DRAIN: begin
                    if (flush) begin
                        state     <= RUN;
                        drain_cnt <= '0;
                    end else if (!out_valid) begin
                        if (drain_cnt <= DRAIN_W'(1)) begin
                            state     <= HALTED;
                            halted    <= 1'b1;
                            drain_cnt <= '0;
                        end else begin
                            drain_cnt <= drain_cnt - DRAIN_W'(1);
                        end
                    end
                end
                HALTED: begin
                    if (resume) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (hazard && !flush && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_decode_ctrl.sv
// Directed bench for pipe_decode_ctrl with hand-computed control bundles.
module tb_pipe_decode_ctrl;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned CNT_W = 16;

    // Bundle bits: j22 jw21 jr20 beq19 bne18 bgez17 mw16 half15 sys14 im13 alu[12:9] ain[8:5] reg[4:0]
    localparam logic [22:0] EXP_BEQ  = 23'h080420;
    localparam logic [22:0] EXP_ADD  = 23'h000221;
    localparam logic [22:0] EXP_SW   = 23'h012240;
    localparam logic [22:0] EXP_JAL  = 23'h600015;
    localparam logic [22:0] EXP_SYS  = 23'h004000;

    localparam logic [31:0] I_BEQ    = 32'h1085_0003;
    localparam logic [31:0] I_BAD    = 32'hFC00_0000;
    localparam logic [31:0] I_ADD    = 32'h010A_4820;
    localparam logic [31:0] I_ADD_R0 = 32'h000A_4820;
    localparam logic [31:0] I_SW     = 32'hAFA2_0004;
    localparam logic [31:0] I_JAL    = 32'h0C00_0010;
    localparam logic [31:0] I_JR     = 32'h03E0_0008;
    localparam logic [31:0] I_SYS    = 32'h0000_000C;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [PC_W-1:0]  in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [22:0]      out_ctrl;
    logic [4:0]       out_rs;
    logic [4:0]       out_rt;
    logic [4:0]       out_rd;
    logic [31:0]      out_instr;
    logic [PC_W-1:0]  out_pc;
    logic             ex_memread;
    logic [4:0]       ex_rd;
    logic             flush;
    logic             resume;
    logic             halted;
    logic [CNT_W-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    pipe_decode_ctrl #(.PC_W(PC_W), .DRAIN_CYCLES(3), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ctrl    (out_ctrl),
        .out_rs      (out_rs),
        .out_rt      (out_rt),
        .out_rd      (out_rd),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .ex_memread  (ex_memread),
        .ex_rd       (ex_rd),
        .flush       (flush),
        .resume      (resume),
        .halted      (halted),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [PC_W-1:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
        ex_memread = 1'b0; ex_rd = '0; flush = 1'b0; resume = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_stall_count", 64'(stall_count), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic decode, 1-cycle latency
        send(I_BEQ, 32'h100);
        #1 check("beq_in_ready", 64'(in_ready), 64'd1);
        cyc();
        in_valid = 1'b0;
        check("beq_out_valid", 64'(out_valid), 64'd1);
        check("beq_ctrl", 64'(out_ctrl), 64'(EXP_BEQ));
        check("beq_rs", 64'(out_rs), 64'd4);
        check("beq_rt", 64'(out_rt), 64'd5);
        check("beq_pc", 64'(out_pc), 64'h100);

        send(I_BAD, 32'h104);
        cyc();
        in_valid = 1'b0;
        check("nop_ctrl", 64'(out_ctrl), 64'd0);
        cyc();
        check("bubble_out_valid", 64'(out_valid), 64'd0);

        // Load-use stall on rs
        ex_memread = 1'b1; ex_rd = 5'd8;
        send(I_ADD, 32'h108);
        #1 check("lu_in_ready", 64'(in_ready), 64'd0);
        cyc();
        check("lu_bubble", 64'(out_valid), 64'd0);
        check("lu_stall_count", 64'(stall_count), 64'd1);
        ex_memread = 1'b0;
        #1 check("lu_release", 64'(in_ready), 64'd1);
        cyc();
        in_valid = 1'b0;
        check("add_ctrl", 64'(out_ctrl), 64'(EXP_ADD));
        check("add_rd", 64'(out_rd), 64'd9);

        // ex_rd == 0 never stalls
        ex_memread = 1'b1; ex_rd = 5'd0;
        send(I_ADD_R0, 32'h10C);
        #1 check("r0_in_ready", 64'(in_ready), 64'd1);
        cyc();
        check("r0_stall_count", 64'(stall_count), 64'd1);

        // Load-use stall via rt of a store
        ex_rd = 5'd2;
        send(I_SW, 32'h200);
        #1 check("sw_rt_in_ready", 64'(in_ready), 64'd0);
        cyc();
        check("sw_rt_stall_count", 64'(stall_count), 64'd2);
        ex_memread = 1'b0;
        cyc();
        check("sw_ctrl", 64'(out_ctrl), 64'(EXP_SW));

        // Backpressure holds outputs
        out_ready = 1'b0;
        send(I_JAL, 32'h204);
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_in_ready", 64'(in_ready), 64'd0);
            cyc();
            check("bp_hold_ctrl", 64'(out_ctrl), 64'(EXP_SW));
            check("bp_hold_pc", 64'(out_pc), 64'h200);
        end
        out_ready = 1'b1;
        #1 check("bp_release", 64'(in_ready), 64'd1);
        cyc();
        check("jal_ctrl", 64'(out_ctrl), 64'(EXP_JAL));
        check("jal_pc", 64'(out_pc), 64'h204);

        // Flush in the same cycle as an accepted JR
        send(I_JR, 32'h208);
        flush = 1'b1;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_no_jr", 64'(out_ctrl), 64'(EXP_JAL));

        // Syscall drain then halt, then resume
        out_ready = 1'b0;
        send(I_SYS, 32'h300);
        cyc();
        in_valid = 1'b0;
        check("sys_ctrl", 64'(out_ctrl), 64'(EXP_SYS));
        check("drain_in_ready", 64'(in_ready), 64'd0);
        cyc();
        check("drain_hold_halted", 64'(halted), 64'd0);
        out_ready = 1'b1;
        cyc();
        check("drain_out_valid_fell", 64'(out_valid), 64'd0);
        for (int i = 1; i < 3; i++) begin
            cyc();
            check("drain_not_halted", 64'(halted), 64'd0);
        end
        cyc();
        check("halted_after_3", 64'(halted), 64'd1);
        in_valid = 1'b1; in_instr = I_ADD_R0;
        #1 check("halted_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check("halted_flush_ignored", 64'(halted), 64'd1);
        resume = 1'b1;
        cyc();
        resume = 1'b0;
        check("resume_halted", 64'(halted), 64'd0);
        check("resume_in_ready", 64'(in_ready), 64'd1);

        // Flush during drain squashes the syscall
        send(I_SYS, 32'h310);
        cyc();
        in_valid = 1'b0;
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        repeat (6) cyc();
        check("squash_halted", 64'(halted), 64'd0);
        check("squash_in_ready", 64'(in_ready), 64'd1);

        // Async reset while halted
        send(I_SYS, 32'h320);
        cyc();
        in_valid = 1'b0;
        repeat (6) cyc();
        check("halt_again", 64'(halted), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_halted", 64'(halted), 64'd0);
        check("async_rst_stall_count", 64'(stall_count), 64'd0);
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        cyc();
        rst_n = 1'b1;
        #1 check("post_rst_in_ready", 64'(in_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
